rv_ddr_arb: RTL and testbench

- Two-port arbiter and sequencer between the RV32 core's instruction-refill port and data port and the single DDR3 controller user (app_*) interface.
- Grants one requester at a time with round-robin, issues one 128-bit burst (BL8 on x16 DDR3) per transaction, and returns read data with a one-cycle ack.
- Sits between the core-side memory interface and the DDR3 controller; one transaction is outstanding at a time.

---
 rtl/rv_ddr_arb.sv | 250 +++++++++++++++++++++++++
 tb/tb_rv_ddr_arb.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rv_ddr_arb.sv
// Round-robin arbiter between the instruction-refill and data ports of the core
// and a single DDR3 controller app_* interface; one burst outstanding at a time.
module rv_ddr_arb #(
  parameter int AW         = 28,
  parameter int DW         = 128,
  parameter int RD_TIMEOUT = 1024
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            calib_done,
  input  logic            i_req,
  input  logic [AW-1:0]   i_addr,
  output logic            i_ack,
  output logic [DW-1:0]   i_rdata,
  input  logic            d_req,
  input  logic            d_we,
  input  logic [AW-1:0]   d_addr,
  input  logic [DW-1:0]   d_wdata,
  input  logic [DW/8-1:0] d_be,
  output logic            d_ack,
  output logic [DW-1:0]   d_rdata,
  output logic [AW-1:0]   app_addr,
  output logic [2:0]      app_cmd,
  output logic            app_en,
  input  logic            app_rdy,
  output logic [DW-1:0]   app_wdf_data,
  output logic [DW/8-1:0] app_wdf_mask,
  output logic            app_wdf_wren,
  output logic            app_wdf_end,
  input  logic            app_wdf_rdy,
  input  logic [DW-1:0]   app_rd_data,
  input  logic            app_rd_data_valid,
  output logic            err
);

  localparam int MW = DW / 8;
  localparam int CW = $clog2(RD_TIMEOUT + 1);
  localparam logic [2:0] CMD_WR = 3'b000;
  localparam logic [2:0] CMD_RD = 3'b001;
  localparam logic GNT_I = 1'b0;
  localparam logic GNT_D = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_WDATA  = 3'd1,
    ST_CMD    = 3'd2,
    ST_RDWAIT = 3'd3,
    ST_DONE   = 3'd4
  } state_e;

  state_e          state_q, state_d;
  logic            last_grant_q, last_grant_d;
  logic            gnt_q, gnt_d;
  logic            we_q, we_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            i_ack_q, i_ack_d;
  logic [DW-1:0]   i_rdata_q, i_rdata_d;
  logic            d_ack_q, d_ack_d;
  logic [DW-1:0]   d_rdata_q, d_rdata_d;
  logic [AW-1:0]   app_addr_q, app_addr_d;
  logic [2:0]      app_cmd_q, app_cmd_d;
  logic            app_en_q, app_en_d;
  logic [DW-1:0]   app_wdf_data_q, app_wdf_data_d;
  logic [MW-1:0]   app_wdf_mask_q, app_wdf_mask_d;
  logic            app_wdf_wren_q, app_wdf_wren_d;
  logic            err_q, err_d;

  logic            pick;
  logic [AW-1:0]   sel_addr;
  logic            sel_we;

  // Arbitration choice: a lone requester wins, otherwise the port not served last.
  always_comb begin
    pick     = GNT_I;
    sel_addr = i_addr;
    sel_we   = 1'b0;
    if (i_req && d_req) begin
      pick = ~last_grant_q;
    end else if (d_req) begin
      pick = GNT_D;
    end else begin
      pick = GNT_I;
    end
    if (pick == GNT_D) begin
      sel_addr = d_addr;
      sel_we   = d_we;
    end else begin
      sel_addr = i_addr;
      sel_we   = 1'b0;
    end
  end

  // Next-state and registered-output computation for the transaction sequencer.
  always_comb begin
    state_d        = state_q;
    last_grant_d   = last_grant_q;
    gnt_d          = gnt_q;
    we_d           = we_q;
    cnt_d          = cnt_q;
    i_ack_d        = 1'b0;
    d_ack_d        = 1'b0;
    i_rdata_d      = i_rdata_q;
    d_rdata_d      = d_rdata_q;
    app_addr_d     = app_addr_q;
    app_cmd_d      = app_cmd_q;
    app_en_d       = app_en_q;
    app_wdf_data_d = app_wdf_data_q;
    app_wdf_mask_d = app_wdf_mask_q;
    app_wdf_wren_d = app_wdf_wren_q;
    err_d          = err_q;

    case (state_q)
      ST_IDLE: begin
        if (calib_done && (i_req || d_req)) begin
          gnt_d        = pick;
          last_grant_d = pick;
          we_d         = sel_we;
          app_addr_d   = {sel_addr[AW-1:3], 3'b000};
          if (sel_we) begin
            app_wdf_data_d = d_wdata;
            app_wdf_mask_d = ~d_be;
            app_wdf_wren_d = 1'b1;
            state_d        = ST_WDATA;
          end else begin
            app_en_d  = 1'b1;
            app_cmd_d = CMD_RD;
            state_d   = ST_CMD;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_WDATA: begin
        if (app_wdf_rdy) begin
          app_wdf_wren_d = 1'b0;
          app_en_d       = 1'b1;
          app_cmd_d      = CMD_WR;
          state_d        = ST_CMD;
        end else begin
          state_d = ST_WDATA;
        end
      end

      ST_CMD: begin
        if (app_rdy) begin
          app_en_d = 1'b0;
          if (we_q) begin
            d_ack_d = 1'b1;
            state_d = ST_DONE;
          end else begin
            cnt_d   = {CW{1'b0}};
            state_d = ST_RDWAIT;
          end
        end else begin
          state_d = ST_CMD;
        end
      end

      ST_RDWAIT: begin
        if (app_rd_data_valid) begin
          state_d = ST_DONE;
          if (gnt_q == GNT_D) begin
            d_rdata_d = app_rd_data;
            d_ack_d   = 1'b1;
          end else begin
            i_rdata_d = app_rd_data;
            i_ack_d   = 1'b1;
          end
        end else if (cnt_q == CW'(RD_TIMEOUT - 1)) begin
          // Abort: acknowledge with zero data so the requester never stalls forever.
          err_d   = 1'b1;
          state_d = ST_DONE;
          if (gnt_q == GNT_D) begin
            d_rdata_d = {DW{1'b0}};
            d_ack_d   = 1'b1;
          end else begin
            i_rdata_d = {DW{1'b0}};
            i_ack_d   = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d        = ST_IDLE;
        app_en_d       = 1'b0;
        app_wdf_wren_d = 1'b0;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= ST_IDLE;
      last_grant_q   <= GNT_D;
      gnt_q          <= GNT_I;
      we_q           <= 1'b0;
      cnt_q          <= {CW{1'b0}};
      i_ack_q        <= 1'b0;
      i_rdata_q      <= {DW{1'b0}};
      d_ack_q        <= 1'b0;
      d_rdata_q      <= {DW{1'b0}};
      app_addr_q     <= {AW{1'b0}};
      app_cmd_q      <= 3'b000;
      app_en_q       <= 1'b0;
      app_wdf_data_q <= {DW{1'b0}};
      app_wdf_mask_q <= {MW{1'b0}};
      app_wdf_wren_q <= 1'b0;
      err_q          <= 1'b0;
    end else begin
      state_q        <= state_d;
      last_grant_q   <= last_grant_d;
      gnt_q          <= gnt_d;
      we_q           <= we_d;
      cnt_q          <= cnt_d;
      i_ack_q        <= i_ack_d;
      i_rdata_q      <= i_rdata_d;
      d_ack_q        <= d_ack_d;
      d_rdata_q      <= d_rdata_d;
      app_addr_q     <= app_addr_d;
      app_cmd_q      <= app_cmd_d;
      app_en_q       <= app_en_d;
      app_wdf_data_q <= app_wdf_data_d;
      app_wdf_mask_q <= app_wdf_mask_d;
      app_wdf_wren_q <= app_wdf_wren_d;
      err_q          <= err_d;
    end
  end

  assign i_ack        = i_ack_q;
  assign i_rdata      = i_rdata_q;
  assign d_ack        = d_ack_q;
  assign d_rdata      = d_rdata_q;
  assign app_addr     = app_addr_q;
  assign app_cmd      = app_cmd_q;
  assign app_en       = app_en_q;
  assign app_wdf_data = app_wdf_data_q;
  assign app_wdf_mask = app_wdf_mask_q;
  assign app_wdf_wren = app_wdf_wren_q;
  assign app_wdf_end  = app_wdf_wren_q;
  assign err          = err_q;

endmodule

// File: tb/tb_rv_ddr_arb.sv
// Directed bench for rv_ddr_arb with a small DDR-controller read responder.
module tb_rv_ddr_arb;
  localparam int AW = 28;
  localparam int DW = 128;
  localparam int MW = DW / 8;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          calib_done = 1'b0;
  logic          i_req = 1'b0;
  logic [AW-1:0] i_addr = '0;
  logic          i_ack;
  logic [DW-1:0] i_rdata;
  logic          d_req = 1'b0;
  logic          d_we = 1'b0;
  logic [AW-1:0] d_addr = '0;
  logic [DW-1:0] d_wdata = '0;
  logic [MW-1:0] d_be = '0;
  logic          d_ack;
  logic [DW-1:0] d_rdata;
  logic [AW-1:0] app_addr;
  logic [2:0]    app_cmd;
  logic          app_en;
  logic          app_rdy = 1'b1;
  logic [DW-1:0] app_wdf_data;
  logic [MW-1:0] app_wdf_mask;
  logic          app_wdf_wren;
  logic          app_wdf_end;
  logic          app_wdf_rdy = 1'b1;
  logic [DW-1:0] app_rd_data = '0;
  logic          app_rd_data_valid = 1'b0;
  logic          err;

  logic          auto_rd = 1'b1;
  logic [DW-1:0] rd_pat = '0;
  int            inj_cnt = 0;
  int            checks = 0;
  int            failures = 0;

  rv_ddr_arb #(.AW(AW), .DW(DW), .RD_TIMEOUT(16)) dut (
    .clk(clk), .reset(reset), .calib_done(calib_done),
    .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_be(d_be),
    .d_ack(d_ack), .d_rdata(d_rdata),
    .app_addr(app_addr), .app_cmd(app_cmd), .app_en(app_en), .app_rdy(app_rdy),
    .app_wdf_data(app_wdf_data), .app_wdf_mask(app_wdf_mask),
    .app_wdf_wren(app_wdf_wren), .app_wdf_end(app_wdf_end), .app_wdf_rdy(app_wdf_rdy),
    .app_rd_data(app_rd_data), .app_rd_data_valid(app_rd_data_valid), .err(err)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Waits for the chosen port's ack; cycle 1 is the cycle the request was raised.
  task automatic wait_ack(input bit port_d, output int cyc);
    cyc = 1;
    for (int k = 0; k < 100; k++) begin
      tick();
      cyc++;
      if ((port_d ? d_ack : i_ack) === 1'b1) return;
    end
    cyc = -1;
  endtask

  // Controller model: read data valid in the cycle after an accepted read command.
  initial begin
    bit acc;
    int seen;
    seen = 0;
    forever begin
      @(negedge clk);
      acc = app_en && app_rdy && (app_cmd == 3'b001) && auto_rd;
      @(posedge clk);
      #1;
      app_rd_data = rd_pat;
      if (inj_cnt != seen) begin
        seen = inj_cnt;
        app_rd_data_valid = 1'b1;
      end else begin
        app_rd_data_valid = acc;
      end
    end
  end

  initial begin
    int cyc, n, dbl, wren_cnt, end_bad, en_cnt, early_en, stray, idx;
    bit seen_en;
    bit order [4];
    logic [2:0] cmd_seen;
    logic [DW-1:0] prev_d;

    repeat (3) tick();
    check_eq("rst_outputs", {i_ack, d_ack, app_en, app_wdf_wren, app_wdf_end, app_cmd, err}, '0);
    check_eq("rst_data", {i_rdata ^ d_rdata ^ app_wdf_data, app_addr, app_wdf_mask}, '0);
    reset = 1'b0;
    calib_done = 1'b1;
    tick();

    // Basic instruction read
    rd_pat = 128'h11223344556677889900AABBCCDDEEFF;
    i_addr = 28'h0000105;
    i_req = 1'b1;
    cyc = 1;
    seen_en = 1'b0;
    for (int k = 0; k < 100; k++) begin
      tick();
      cyc++;
      if (app_en && !seen_en) begin
        seen_en = 1'b1;
        check_eq("rd_addr", app_addr, 28'h0000100);
        check_eq("rd_cmd", app_cmd, 3'b001);
      end
      if (i_ack) break;
    end
    i_req = 1'b0;
    check_eq("rd_latency", cyc, 4);
    check_eq("rd_data", i_rdata, 128'h11223344556677889900AABBCCDDEEFF);
    check_eq("rd_no_dack", d_ack, 1'b0);
    tick();
    check_eq("ack_one_cycle", i_ack, 1'b0);

    // Round robin from reset with both ports held
    reset = 1'b1;
    tick();
    reset = 1'b0;
    rd_pat = 128'hCAFE0000_0000BEEF_12345678_9ABCDEF0;
    d_addr = 28'h0000208;
    d_we = 1'b0;
    i_req = 1'b1;
    d_req = 1'b1;
    n = 0;
    dbl = 0;
    for (int k = 0; k < 200 && n < 4; k++) begin
      tick();
      if (i_ack && d_ack) dbl++;
      if (i_ack) begin order[n] = 1'b0; n++; end
      else if (d_ack) begin order[n] = 1'b1; n++; end
    end
    i_req = 1'b0;
    d_req = 1'b0;
    check_eq("rr_count", n, 4);
    check_eq("rr_order", {order[0], order[1], order[2], order[3]}, 4'b0101);
    check_eq("rr_double_ack", dbl, 0);
    check_eq("rr_drdata", d_rdata, 128'hCAFE0000_0000BEEF_12345678_9ABCDEF0);
    repeat (2) tick();

    // Write with back-pressure on the write-data channel
    prev_d = d_rdata;
    d_we = 1'b1;
    d_addr = 28'h000030C;
    d_wdata = {16{8'hA5}};
    d_be = 16'h000F;
    app_wdf_rdy = 1'b0;
    d_req = 1'b1;
    wren_cnt = 0; end_bad = 0; en_cnt = 0; early_en = 0;
    cmd_seen = 3'b111;
    for (int k = 0; k < 100; k++) begin
      tick();
      if (app_wdf_end !== app_wdf_wren) end_bad++;
      if (app_wdf_wren) begin
        wren_cnt++;
        if (wren_cnt == 1) begin
          check_eq("wr_data", app_wdf_data, {16{8'hA5}});
          check_eq("wr_mask", app_wdf_mask, 16'hFFF0);
          check_eq("wr_addr", app_addr, 28'h0000308);
        end
        if (wren_cnt == 4) app_wdf_rdy = 1'b1;
      end
      if (app_en) begin
        en_cnt++;
        cmd_seen = app_cmd;
        if (wren_cnt < 4 || app_wdf_wren) early_en++;
      end
      if (d_ack) break;
    end
    d_req = 1'b0;
    d_we = 1'b0;
    check_eq("wr_wren_cycles", wren_cnt, 4);
    check_eq("wr_end_eq_wren", end_bad, 0);
    check_eq("wr_cmd_once", en_cnt, 1);
    check_eq("wr_cmd_code", cmd_seen, 3'b000);
    check_eq("wr_data_before_cmd", early_en, 0);
    check_eq("wr_ack", d_ack, 1'b1);
    check_eq("wr_drdata_kept", d_rdata, prev_d);
    repeat (2) tick();

    // Calibration gating
    calib_done = 1'b0;
    rd_pat = 128'h0F0F0F0F_F0F0F0F0_0F0F0F0F_F0F0F0F0;
    i_addr = 28'h0000040;
    i_req = 1'b1;
    en_cnt = 0;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (app_en) en_cnt++;
    end
    check_eq("calib_block", en_cnt, 0);
    calib_done = 1'b1;
    tick();
    check_eq("calib_en_cycle2", app_en, 1'b1);
    calib_done = 1'b0;
    wait_ack(1'b0, cyc);
    i_req = 1'b0;
    check_eq("calib_drop_completes", cyc > 0, 1'b1);
    check_eq("calib_drop_data", i_rdata, 128'h0F0F0F0F_F0F0F0F0_0F0F0F0F_F0F0F0F0);
    calib_done = 1'b1;
    repeat (2) tick();

    // Read timeout
    check_eq("err_clear_before", err, 1'b0);
    auto_rd = 1'b0;
    rd_pat = 128'hDEADBEEF_DEADBEEF_DEADBEEF_DEADBEEF;
    i_addr = 28'h0000080;
    i_req = 1'b1;
    for (int k = 0; k < 20 && !app_en; k++) tick();
    tick();
    idx = 0;
    for (int k = 0; k < 40 && !i_ack; k++) begin
      tick();
      idx++;
    end
    i_req = 1'b0;
    check_eq("to_ack_index", idx, 16);
    check_eq("to_rdata_zero", i_rdata, '0);
    check_eq("to_err", err, 1'b1);
    repeat (2) tick();
    inj_cnt++;
    stray = 0;
    for (int k = 0; k < 6; k++) begin
      tick();
      if (i_ack || d_ack) stray++;
    end
    check_eq("to_stray_valid", stray, 0);
    check_eq("to_rdata_kept", i_rdata, '0);
    check_eq("to_err_sticky", err, 1'b1);

    // Reset during RDWAIT
    i_addr = 28'h0000100;
    i_req = 1'b1;
    for (int k = 0; k < 20 && !app_en; k++) tick();
    repeat (3) tick();
    reset = 1'b1;
    i_req = 1'b0;
    tick();
    check_eq("mid_rst_ctrl", {i_ack, d_ack, app_en, app_wdf_wren, app_wdf_end, app_cmd, err}, '0);
    check_eq("mid_rst_data", {i_rdata | d_rdata | app_wdf_data, app_addr, app_wdf_mask}, '0);
    reset = 1'b0;
    auto_rd = 1'b1;
    rd_pat = 128'h5A5A5A5A_00000000_FFFFFFFF_A5A5A5A5;
    tick();
    i_addr = 28'h000010F;
    i_req = 1'b1;
    wait_ack(1'b0, cyc);
    i_req = 1'b0;
    check_eq("post_rst_latency", cyc, 4);
    check_eq("post_rst_data", i_rdata, 128'h5A5A5A5A_00000000_FFFFFFFF_A5A5A5A5);
    check_eq("post_rst_err", err, 1'b0);
    repeat (2) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
